// File: rtl/arith_pkg.sv
// arith_pkg: shared opcodes, flag indices and config check
// for the chunk-pipelined add/sub datapath.
`ifndef ARITH_PKG_SV
`define ARITH_PKG_SV

`define ARITH_LEGAL(W, C) \
  (((C) > 0) && ((W) >= (C)) && (((W) % (C)) == 0))

package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;
  localparam int NFLG  = 4;

endpackage

`endif

// File: rtl/add_chunk.sv
// add_chunk: combinational CHUNK-bit ripple adder slice
// exposing the carry into its top bit for overflow.
module add_chunk
  import arith_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub_acc.sv
// pipelined_add_sub_acc: add/sub with one carry chunk per
// stage, global stall, status flags and an accumulator.
module pipelined_add_sub_acc
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!`ARITH_LEGAL(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  logic [STAGES-1:0] sv;
  logic [STAGES-1:0] sacc;
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  ss [STAGES];
  logic              sc [STAGES];

  logic [WIDTH-1:0]  xa [STAGES];
  logic [WIDTH-1:0]  xb [STAGES];
  logic [WIDTH-1:0]  xs [STAGES];
  logic [WIDTH-1:0]  ns [STAGES];
  logic              xc [STAGES];
  logic              xv [STAGES];
  logic              xacc [STAGES];
  logic              nc [STAGES];
  logic              ncm [STAGES];

  logic [NFLG-1:0]   flg;
  logic [NFLG-1:0]   nflg;
  logic [WIDTH-1:0]  acc;
  logic              advance;
  logic              busy;
  logic              acc_busy;
  logic              fire;

  assign out_valid = sv[STAGES-1];
  assign advance   = !(out_valid && !out_ready);
  assign busy      = |sv;
  assign acc_busy  = |(sv & sacc);
  // acc beats need an empty pipe so they see the updated acc
  assign in_ready  = advance && !acc_busy && !(acc_en && busy);
  assign fire      = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] cs;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign xa[k]   = acc_en ? acc : a;
      assign xb[k]   = (sub == OP_SUB) ? ~b : b;
      assign xs[k]   = '0;
      assign xc[k]   = sub;
      assign xv[k]   = fire;
      assign xacc[k] = acc_en;
    end else begin : g_body
      assign xa[k]   = sa[k-1];
      assign xb[k]   = sb[k-1];
      assign xs[k]   = ss[k-1];
      assign xc[k]   = sc[k-1];
      assign xv[k]   = sv[k-1];
      assign xacc[k] = sacc[k-1];
    end

    add_chunk #(
      .CHUNK(CHUNK)
    ) u_add (
      .x       (xa[k][k*CHUNK +: CHUNK]),
      .y       (xb[k][k*CHUNK +: CHUNK]),
      .ci      (xc[k]),
      .s       (cs),
      .co      (nc[k]),
      .c_msb_in(ncm[k])
    );

    always_comb begin
      merged = xs[k];
      merged[k*CHUNK +: CHUNK] = cs;
    end

    assign ns[k] = merged;
  end

  always_comb begin
    nflg        = '0;
    nflg[FLG_C] = nc[STAGES-1];
    nflg[FLG_V] = nc[STAGES-1] ^ ncm[STAGES-1];
    nflg[FLG_Z] = (ns[STAGES-1] == '0);
    nflg[FLG_N] = ns[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv   <= '0;
      sacc <= '0;
      flg  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sa[k] <= '0;
        sb[k] <= '0;
        ss[k] <= '0;
        sc[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        sv[k]   <= xv[k];
        sacc[k] <= xacc[k];
        sa[k]   <= xa[k];
        sb[k]   <= xb[k];
        ss[k]   <= ns[k];
        sc[k]   <= nc[k];
      end
      flg <= nflg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (out_valid && out_ready && sacc[STAGES-1]) begin
      acc <= ss[STAGES-1];
    end
  end

  assign sum  = ss[STAGES-1];
  assign cout = flg[FLG_C];
  assign ovf  = flg[FLG_V];
  assign zero = flg[FLG_Z];
  assign neg  = flg[FLG_N];

endmodule

// File: tb/tb_pipelined_add_sub_acc.sv
// tb_pipelined_add_sub_acc: directed + random checks against
// a queue-based arithmetic model of the add/sub pipeline.
module tb_pipelined_add_sub_acc;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             acc_en = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  int n_chk = 0;
  int n_fail = 0;
  int n_fire = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic c;
    logic v;
    logic z;
    logic n;
    bit   acc;
    int   age;
  } beat_t;

  beat_t q[$];
  logic [WIDTH-1:0] m_acc = '0;

  pipelined_add_sub_acc #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t model(input logic [WIDTH-1:0] aa,
                                  input logic [WIDTH-1:0] bb,
                                  input logic s, input bit ac);
    beat_t t;
    int ua, ub, sa_, sb_, r;
    ua  = aa;
    ub  = bb;
    sa_ = $signed(aa);
    sb_ = $signed(bb);
    if (s) begin
      t.sum = aa - bb;
      t.c   = (ua >= ub);
      r     = sa_ - sb_;
    end else begin
      t.sum = aa + bb;
      t.c   = (ua + ub) >= (1 << WIDTH);
      r     = sa_ + sb_;
    end
    t.v   = (r > (1 << (WIDTH-1)) - 1) || (r < -(1 << (WIDTH-1)));
    t.z   = (t.sum == '0);
    t.n   = t.sum[WIDTH-1];
    t.acc = ac;
    t.age = 0;
    return t;
  endfunction

  // model: decides what the coming rising edge does
  always @(negedge clk) begin : mdl
    bit    exp_ov, exp_ir, stall, has_acc, fire, hand;
    beat_t nb;
    if (!rst_n) begin
      q.delete();
      m_acc = '0;
    end else begin
      exp_ov  = (q.size() > 0) && (q[0].age == STAGES-1);
      has_acc = 0;
      foreach (q[i]) if (q[i].acc) has_acc = 1;
      stall   = exp_ov && !out_ready;
      exp_ir  = !stall && !has_acc && !(acc_en && q.size() > 0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      if (exp_ov) begin
        chk("sum", {16'b0, sum}, {16'b0, q[0].sum});
        chk("cout", {31'b0, cout}, {31'b0, q[0].c});
        chk("ovf", {31'b0, ovf}, {31'b0, q[0].v});
        chk("zero", {31'b0, zero}, {31'b0, q[0].z});
        chk("neg", {31'b0, neg}, {31'b0, q[0].n});
      end
      fire = in_valid && exp_ir;
      hand = exp_ov && out_ready;
      if (fire) nb = model(acc_en ? m_acc : a, b, sub, acc_en);
      if (acc_clr) m_acc = '0;
      else if (hand && q[0].acc) m_acc = q[0].sum;
      if (hand) void'(q.pop_front());
      if (!stall) foreach (q[i]) q[i].age++;
      if (fire) begin
        q.push_back(nb);
        n_fire++;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] aa,
                      input logic [WIDTH-1:0] bb,
                      input logic s, input logic e);
    int t;
    int f0;
    a        = aa;
    b        = bb;
    sub      = s;
    acc_en   = e;
    in_valid = 1'b1;
    f0       = n_fire;
    t        = 0;
    while (n_fire == f0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (n_fire == f0) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    acc_en   = 1'b0;
  endtask

  task automatic expect_lit(input string nm,
                            input logic [WIDTH-1:0] es,
                            input logic ec, input logic ev,
                            input logic ez, input logic en,
                            input logic er, input bit clr);
    repeat (STAGES-1) @(negedge clk);
    chk({nm, "_early"}, {31'b0, out_valid}, 0);
    chk({nm, "_ready"}, {31'b0, in_ready}, {31'b0, er});
    if (clr) begin
      @(posedge clk);
      #1;
      acc_clr = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_valid"}, {31'b0, out_valid}, 1);
    chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
    chk({nm, "_zero"}, {31'b0, zero}, {31'b0, ez});
    chk({nm, "_neg"}, {31'b0, neg}, {31'b0, en});
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int cyc;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_flags", {28'b0, cout, ovf, zero, neg}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    expect_lit("add_ovf", 16'h8000, 0, 1, 0, 1, 1, 0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    expect_lit("sub_neg", 16'hFFFE, 0, 0, 0, 1, 1, 0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    expect_lit("sub_ovf", 16'h7FFF, 1, 1, 0, 0, 1, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_lit("add_wrap", 16'h0000, 1, 0, 1, 0, 1, 0);

    f0 = n_fire;
    in_valid = 1'b1;
    repeat (8) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("throughput", n_fire - f0, 8);

    f0  = n_fire;
    cyc = 0;
    while (n_fire - f0 < 32 && cyc < 2000) begin
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      acc_en    = ($urandom % 10) == 0;
      acc_clr   = ($urandom % 16) == 0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_beats", n_fire - f0, 32);
    in_valid  = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain", q.size(), 0);

    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    send(WIDTH'($urandom), 16'h0010, 1'b0, 1'b1);
    expect_lit("acc1", 16'h0010, 0, 0, 0, 0, 0, 0);
    send(WIDTH'($urandom), 16'h0010, 1'b0, 1'b1);
    expect_lit("acc2", 16'h0020, 0, 0, 0, 0, 0, 0);
    send(WIDTH'($urandom), 16'h0010, 1'b0, 1'b1);
    expect_lit("acc3", 16'h0030, 0, 0, 0, 0, 0, 1);
    send(WIDTH'($urandom), 16'h0007, 1'b0, 1'b1);
    expect_lit("acc_clr_wins", 16'h0007, 0, 0, 0, 0, 0, 0);
    send(WIDTH'($urandom), 16'h0005, 1'b0, 1'b1);
    expect_lit("acc_pre_rst", 16'h000C, 0, 0, 0, 0, 0, 0);

    in_valid = 1'b1;
    repeat (4) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("inflight_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 0);
    chk("async_rst_sum", {16'b0, sum}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", {31'b0, in_ready}, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(WIDTH'($urandom), 16'h0001, 1'b0, 1'b1);
    expect_lit("acc_after_rst", 16'h0001, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
